fir_shift_controller: RTL
=========================

Name: fir_shift_controller

Overview:
- Initiator side of the FIR tap-chain shift interface.
- Pops samples from an upstream first-word-fall-through (FWFT) FIFO and drives the first tap's x_in plus the chain-wide shift strobe, one sample at a time.
- Waits for the tap-sum adder tree to settle, applies integer decimation, and pushes the filtered result into a downstream FIFO.
- Sits between the input FIFO and output FIFO of each FIR stage in the FM demod chain (channel filter, audio LPF, decimators).

Parameters:
- DATA_WIDTH, 32, width of samples, tap sum and FIFO data (signed, quantized, 10 fractional bits).
- DECIMATION, 1, write one output per DECIMATION accepted samples; must be >= 1.
- SUM_LATENCY, 1, cycles from the shift cycle's clock edge until sum_in is valid (adder-tree pipeline depth); must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_dout  in  DATA_WIDTH  input FIFO head data; valid whenever in_empty=0 (FWFT)
- in_empty  in  1  input FIFO empty
- in_rd_en  out  1  input FIFO pop; combinational, one cycle per sample
- x_out  out  DATA_WIDTH  sample to tap 0 x_in; registered
- shift  out  1  chain shift strobe, one-cycle pulse; registered state decode
- sum_in  in  DATA_WIDTH  sum of all tap_out values; stable between shifts
- out_din  out  DATA_WIDTH  output FIFO write data
- out_full  in  1  output FIFO full
- out_wr_en  out  1  output FIFO push; combinational
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE; x_reg=0; wait_cnt=0; decim_cnt=0.
  - All outputs 0: in_rd_en, shift, out_wr_en, busy, x_out, out_din.
- Datapath:
  - x_out = x_reg at all times.
  - out_din = sum_in while out_wr_en=1, else 0.
  - sum_in is passed through unmodified. No rescaling or saturation; dequantization is done in the taps.
- FSM states: IDLE, SHIFT, WAIT, EMIT.
  - IDLE:
    - If in_empty=0: in_rd_en=1, x_reg<=in_dout, go to SHIFT.
    - Otherwise stay in IDLE with no pop.
  - SHIFT:
    - shift=1 for exactly this one cycle; x_out=x_reg.
    - wait_cnt<=SUM_LATENCY-1; go to WAIT.
  - WAIT:
    - If wait_cnt==0, go to EMIT; otherwise decrement.
    - WAIT therefore lasts exactly SUM_LATENCY cycles.
  - EMIT, when decim_cnt==DECIMATION-1:
    - If out_full=0: out_wr_en=1, decim_cnt<=0, go to IDLE.
    - If out_full=1: stay in EMIT; out_wr_en=0; no further pops or shifts.
    - sum_in stays valid while stalled because the taps hold without shift.
  - EMIT, otherwise: decim_cnt<=decim_cnt+1, no write, go to IDLE.
- Timing, SUM_LATENCY=1, no backpressure:
  - in_rd_en at cycle N, shift at N+1, WAIT at N+2, out_wr_en at N+3.
  - Next in_rd_en no earlier than N+4.
  - Throughput: one sample per SUM_LATENCY+3 cycles.
- Invariants:
  - Never more than one pop per shift.
  - Never pop while a sample is in flight.
  - shift is never asserted outside SHIFT; in_rd_en is never asserted outside IDLE.
- Boundary conditions:
  - in_empty rising during WAIT/EMIT: no effect.
  - out_full toggling while not in EMIT: no effect.
  - out_full=1 and in_empty=0 in EMIT: no pop.
  - DECIMATION=1: every sample produces a write.
  - decim_cnt wraps to 0 only on a successful write.
  - Reset mid-operation: the in-flight sample is dropped with no write, decim phase returns to 0, and no pulse is emitted in the reset cycle.

Test Plan:
- Bench setup:
  - Bench model: sum_in register loads 2*x_in on shift (mimics a single tap); SUM_LATENCY=1, DECIMATION=1.
  - Input FIFO holds 0x10, 0x20, 0x30.
- Basic streaming -> out_wr_en with out_din=0x20, 0x40, 0x60; pops exactly 3; shift pulses exactly 3.
- Cycle timing -> in_rd_en at cycle N, shift at N+1, out_wr_en at N+3; next in_rd_en at N+4.
- Decimation, DECIMATION=3, 6 samples 1..6 -> exactly 2 writes, out_din=6 then 12 (samples 3 and 6).
- Backpressure: out_full=1 for 5 cycles at EMIT -> FSM holds, no pop/shift/write; write occurs in the cycle out_full falls with the correct sum; no sample lost.
- Starvation, SUM_LATENCY=3: in_empty=1 for 10 cycles between samples -> busy=0 and no strobes while empty; each write arrives 5 cycles after its pop.
- Reset mid-WAIT (async pulse): all outputs 0 immediately; no write for the dropped sample; the next sample processes normally with decim_cnt restarted at 0.

Source files
------------

// File: rtl/fir_shift_controller_if.sv
// fir_shift_controller_if: FIFO and tap-chain handshake bundle for one FIR stage
interface fir_shift_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_dout;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] x_out;
    logic                  shift;
    logic [DATA_WIDTH-1:0] sum_in;
    logic [DATA_WIDTH-1:0] out_din;
    logic                  out_full;
    logic                  out_wr_en;
    logic                  busy;
    modport master (
        input  in_dout, in_empty, sum_in, out_full,
        output in_rd_en, x_out, shift, out_din, out_wr_en, busy
    );
    modport slave (
        output in_dout, in_empty, sum_in, out_full,
        input  in_rd_en, x_out, shift, out_din, out_wr_en, busy
    );
endinterface

// File: rtl/fir_shift_controller.sv
// fir_shift_controller: pops FWFT samples into the tap chain, waits for the sum, writes decimated results
module fir_shift_controller #(
    parameter int DATA_WIDTH  = 32,
    parameter int DECIMATION  = 1,
    parameter int SUM_LATENCY = 1
) (
    input logic clock,
    input logic reset,
    fir_shift_controller_if.master bus
);
    localparam int WW = $clog2(SUM_LATENCY + 1);
    localparam int DW = $clog2(DECIMATION + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT, EMIT} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] x_reg;
    logic [WW-1:0]         wait_cnt;
    logic [DW-1:0]         decim_cnt;
    logic                  last;
    logic                  rd;
    logic                  wr;
    assign last = decim_cnt == DW'(DECIMATION - 1);
    // FIFO strobes are combinational so each handshake lands in the cycle that decides it; reset masks them
    always_comb begin
        rd            = !reset && state == IDLE && !bus.in_empty;
        wr            = !reset && state == EMIT && last && !bus.out_full;
        bus.in_rd_en  = rd;
        bus.out_wr_en = wr;
        bus.out_din   = wr ? bus.sum_in : '0;
        bus.shift     = state == SHIFT;
        bus.busy      = state != IDLE;
        bus.x_out     = x_reg;
    end
    // Walk one sample through pop, chain shift, adder settle and decimated emit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            x_reg     <= '0;
            wait_cnt  <= '0;
            decim_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (!bus.in_empty) begin
                    x_reg <= bus.in_dout;
                    state <= SHIFT;
                end
                SHIFT: begin
                    wait_cnt <= WW'(SUM_LATENCY - 1);
                    state    <= WAIT;
                end
                WAIT: if (wait_cnt == '0) state <= EMIT;
                      else wait_cnt <= wait_cnt - WW'(1);
                EMIT: if (!last) begin
                    decim_cnt <= decim_cnt + DW'(1);
                    state     <= IDLE;
                end else if (!bus.out_full) begin
                    decim_cnt <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
